// File: rtl/md_hilo_ctrl.sv
// HI/LO result holder and decode interlock downstream of the MulDiv unit.
// Tracks one in-flight mult/div, latches its result, forwards HI/LO reads and watches latency.
module md_hilo_ctrl #(
  parameter int unsigned MAX_LAT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic        md_done,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [7:0] LAT_LAST = 8'(MAX_LAT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        timeout_q, timeout_d;

  logic        req_any;
  logic        done_in_busy;
  logic        wd_expire;
  logic        wr_result;
  logic        mthi_acc;
  logic        mtlo_acc;

  // Handshake: md_done is a one-cycle pulse qualifying md_hi/md_lo; decode
  // requests are held by the requester for as long as stall is high and
  // are consumed in the first cycle stall is low.
  assign req_any      = start | mfhi | mflo | mthi | mtlo;
  assign done_in_busy = (state_q == S_BUSY) && md_done;
  assign stall        = req_any && (state_q != S_IDLE) && !done_in_busy;
  assign wd_expire    = (cnt_q == LAT_LAST) && !md_done;
  assign mthi_acc     = mthi && !stall;
  assign mtlo_acc     = mtlo && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    wr_result = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (start && !cancel) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (md_done) begin
          // A flush in the completion cycle drops the result and any new issue.
          cnt_d   = 8'd0;
          state_d = S_IDLE;
          if (!cancel) begin
            wr_result = 1'b1;
            if (start) begin
              state_d = S_BUSY;
            end
          end
        end else if (wd_expire) begin
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else if (cancel) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (md_done) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (wd_expire) begin
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A move-to in the completion cycle is younger than the mult/div, so it wins.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wr_result) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end
    if (mthi_acc) begin
      hi_d = wdata;
    end
    if (mtlo_acc) begin
      lo_d = wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (mfhi) begin
      if (mthi_acc) begin
        rdata = wdata;
      end else if (done_in_busy) begin
        rdata = md_hi;
      end else begin
        rdata = hi_q;
      end
    end else if (mflo) begin
      if (mtlo_acc) begin
        rdata = wdata;
      end else if (done_in_busy) begin
        rdata = md_lo;
      end else begin
        rdata = lo_q;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: result latch, interlock, flush, ordering,
// back-to-back issue, watchdog and asynchronous reset, with a small result queue.
module tb_md_hilo_ctrl;

  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_BUSY  = 32'd1;
  localparam logic [31:0] ST_DRAIN = 32'd2;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cancel;
  logic        md_done;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        mfhi;
  logic        mflo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  md_hilo_ctrl #(.MAX_LAT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .md_done   (md_done),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .mfhi      (mfhi),
    .mflo      (mflo),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clr_inputs();
    start   = 1'b0;
    cancel  = 1'b0;
    md_done = 1'b0;
    md_hi   = 32'd0;
    md_lo   = 32'd0;
    mfhi    = 1'b0;
    mflo    = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wdata   = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_done(input logic [31:0] h, input logic [31:0] l);
    md_done = 1'b1;
    md_hi   = h;
    md_lo   = l;
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mfhi = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    clr_inputs();
    tick();

    // Basic issue with mflo interlock and same-cycle forward (-15 * -4 = 60).
    start = 1'b1;
    #1;
    check("b_start_stall", {31'd0, stall}, 32'd0);
    check("b_start_busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    mflo  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("b_wait_busy", {31'd0, busy}, 32'd1);
      check("b_wait_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    drive_done(32'h0000_0000, 32'h0000_003C);
    exp_q.push_back(32'h0000_003C);
    #1;
    check("b_done_busy", {31'd0, busy}, 32'd1);
    check("b_done_stall", {31'd0, stall}, 32'd0);
    check("b_done_fwd", rdata, 32'h0000_003C);
    tick();
    clr_inputs();
    #1;
    check("b_after_busy", {31'd0, busy}, 32'd0);
    check("b_after_hi", hi, 32'd0);
    check("b_after_lo", lo, exp_q.pop_front());
    check("b_after_timeout", {31'd0, timeout}, 32'd0);
    tick();

    // Flush: cancel one cycle after issue, result arrives in DRAIN and is dropped.
    start = 1'b1;
    tick();
    start  = 1'b0;
    cancel = 1'b1;
    #1;
    check("f_state_busy", {30'd0, dbg_state}, ST_BUSY);
    tick();
    cancel = 1'b0;
    mfhi   = 1'b1;
    #1;
    check("f_state_drain", {30'd0, dbg_state}, ST_DRAIN);
    check("f_drain_stall", {31'd0, stall}, 32'd1);
    tick();
    drive_done(32'hFFFF_FFFF, 32'h1234_5678);
    #1;
    check("f_done_stall", {31'd0, stall}, 32'd1);
    check("f_done_rdata", rdata, 32'd0);
    tick();
    clr_inputs();
    #1;
    check("f_idle", {30'd0, dbg_state}, ST_IDLE);
    check("f_lo_kept", lo, 32'h0000_003C);
    check("f_hi_kept", hi, 32'd0);
    tick();

    // mthi beats md_hi in the completion cycle; start there is accepted back-to-back.
    start = 1'b1;
    tick();
    drive_done(32'hAAAA_0000, 32'h0000_0011);
    exp_q.push_back(32'h0000_0011);
    mthi  = 1'b1;
    wdata = 32'h0000_5555;
    mfhi  = 1'b1;
    start = 1'b1;
    #1;
    check("w_stall", {31'd0, stall}, 32'd0);
    check("w_rdata_mthi", rdata, 32'h0000_5555);
    tick();
    clr_inputs();
    #1;
    check("w_hi", hi, 32'h0000_5555);
    check("w_lo", lo, exp_q.pop_front());
    check("w_b2b_busy", {31'd0, busy}, 32'd1);
    drive_done(32'h0000_0001, 32'h0000_0002);
    mthi  = 1'b1;
    mtlo  = 1'b1;
    mflo  = 1'b1;
    wdata = 32'h0000_CAFE;
    #1;
    check("w2_rdata", rdata, 32'h0000_CAFE);
    tick();
    clr_inputs();
    #1;
    check("w2_hi", hi, 32'h0000_CAFE);
    check("w2_lo", lo, 32'h0000_CAFE);
    check("w2_busy", {31'd0, busy}, 32'd0);

    // IDLE moves, read priority, and a spurious md_done.
    mthi  = 1'b1;
    wdata = 32'h0000_1234;
    #1;
    check("i_mthi_stall", {31'd0, stall}, 32'd0);
    check("i_no_read", rdata, 32'd0);
    tick();
    clr_inputs();
    mfhi = 1'b1;
    mflo = 1'b1;
    #1;
    check("i_prio_hi", rdata, 32'h0000_1234);
    mfhi = 1'b0;
    #1;
    check("i_mflo", rdata, 32'h0000_CAFE);
    mtlo  = 1'b1;
    wdata = 32'h0000_BEEF;
    #1;
    check("i_mtlo_fwd", rdata, 32'h0000_BEEF);
    tick();
    clr_inputs();
    drive_done(32'h0000_0009, 32'h0000_0009);
    tick();
    clr_inputs();
    #1;
    check("i_spur_hi", hi, 32'h0000_1234);
    check("i_spur_lo", lo, 32'h0000_BEEF);
    check("i_spur_busy", {31'd0, busy}, 32'd0);

    // Watchdog with MAX_LAT=8: busy exactly 8 cycles, rejected mthi while busy.
    start = 1'b1;
    tick();
    start = 1'b0;
    mthi  = 1'b1;
    wdata = 32'h0000_DEAD;
    #1;
    check("t_mthi_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      #1;
      check("t_busy", {31'd0, busy}, 32'd1);
      check("t_no_timeout", {31'd0, timeout}, 32'd0);
      tick();
    end
    #1;
    check("t_last_busy", {31'd0, busy}, 32'd1);
    tick();
    clr_inputs();
    #1;
    check("t_idle", {31'd0, busy}, 32'd0);
    check("t_timeout", {31'd0, timeout}, 32'd1);
    check("t_hi_kept", hi, 32'h0000_1234);
    drive_done(32'h0000_0077, 32'h0000_0077);
    tick();
    clr_inputs();
    #1;
    check("t_late_lo", lo, 32'h0000_BEEF);
    check("t_sticky", {31'd0, timeout}, 32'd1);

    // Asynchronous reset between edges while BUSY.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("r_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("r_async_busy", {31'd0, busy}, 32'd0);
    check("r_async_hi", hi, 32'd0);
    check("r_async_lo", lo, 32'd0);
    check("r_async_timeout", {31'd0, timeout}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    #1;
    check("r_post_state", {30'd0, dbg_state}, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_hilo_ctrl.md
# md_hilo_ctrl

HI/LO result holder and pipeline interlock that sits directly downstream of the MulDiv unit. It tracks an issued multiply/divide until MulDiv pulses its ready output, then latches the 64-bit result into HI/LO. It serves MFHI/MFLO/MTHI/MTLO from the decode stage and asserts `stall` whenever an HI/LO access would race an in-flight operation. It also handles flush-on-exception and a latency watchdog.

## Interface
Parameters:
- `MAX_LAT`, 40: watchdog limit in cycles for an in-flight operation; legal range 2..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  mult/div issued to MulDiv this cycle
- `cancel`  in  1  pipeline flush; kills the in-flight operation
- `md_done`  in  1  one-cycle ready pulse from MulDiv
- `md_hi`  in  32  MulDiv HI result, valid while `md_done`=1
- `md_lo`  in  32  MulDiv LO result, valid while `md_done`=1
- `mfhi`  in  1  read request for HI
- `mflo`  in  1  read request for LO
- `mthi`  in  1  write request for HI
- `mtlo`  in  1  write request for LO
- `wdata`  in  32  data for `mthi`/`mtlo`
- `rdata`  out  32  combinational read data
- `stall`  out  1  combinational; decode must hold the current request
- `busy`  out  1  1 when state ≠ IDLE
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `timeout`  out  1  sticky watchdog flag

## Operation
- Reset (async): state=IDLE, `hi`=0, `lo`=0, counter=0, `timeout`=0. `busy`=0 and `stall`=0 whenever no request is present.
- FSM states: IDLE, BUSY, DRAIN.
  - IDLE, `start`=1 and `cancel`=0: go to BUSY, counter=0. If `start` and `cancel` are both 1, stay in IDLE (the instruction is flushed).
  - BUSY, `md_done`=1: write `hi`←`md_hi` and `lo`←`md_lo`. Then go to BUSY (counter=0) if `start`=1 and `cancel`=0, otherwise go to IDLE.
  - BUSY, `cancel`=1 and `md_done`=0: go to DRAIN.
  - BUSY, `cancel`=1 and `md_done`=1: do not write; go to IDLE.
  - DRAIN, `md_done`=1: discard the result; go to IDLE.
  - BUSY or DRAIN, counter == `MAX_LAT`-1 and `md_done`=0: go to IDLE, set `timeout`=1, leave HI/LO unchanged.
- Counter: 8 bits. Increments each cycle in BUSY or DRAIN and is held at 0 in IDLE.
- `md_done` in IDLE is spurious and ignored.
- `stall` = (any of `start`/`mfhi`/`mflo`/`mthi`/`mtlo`) AND state ≠ IDLE AND NOT (state==BUSY AND `md_done`).
  - In DRAIN, `stall` stays asserted even during the `md_done` cycle.
- Writes: `mthi`/`mtlo` take effect only when `stall`=0.
  - In the BUSY+`md_done` cycle, `mthi` overrides `md_hi` for `hi`, and `mtlo` overrides `md_lo` for `lo` (program order).
  - `mthi` and `mtlo` in the same cycle both write `wdata`.
- Reads (`rdata`): `mfhi` has priority over `mflo`. Source order:
  1. `wdata`, if the matching `mt*` is accepted the same cycle.
  2. `md_hi`/`md_lo`, in the BUSY+`md_done` cycle.
  3. The `hi`/`lo` register.
- `rdata`=0 when neither `mfhi` nor `mflo` is asserted.
- `timeout` is cleared only by `reset`.

## Timing
- Result latency: HI/LO are visible on the outputs one edge after `md_done`, and forwarded on `rdata` in the same cycle as `md_done`.
- Stall is zero-cycle: an `mf*` in the `md_done` cycle proceeds without a bubble.
- Back-to-back: `start` in the `md_done` cycle is accepted and `busy` stays 1 with no gap.
- Reset mid-operation: the FSM goes to IDLE immediately, asynchronously. A later `md_done` from the old operation is ignored, which is acceptable because MulDiv shares the same reset.
- Watchdog: in BUSY with no `md_done`, `timeout` rises on the edge ending cycle `MAX_LAT`-1 after entry.

## Test plan
- Basic: `start`, then `md_done` 3 cycles later with `md_hi`=0x00000000 and `md_lo`=0x0000003C (MulDiv result of −15 × −4) → `busy`=1 for 4 cycles, then `hi`=0 and `lo`=0x3C, `timeout`=0.
- Interlock and forward: `mflo` held from the cycle after `start` → `stall`=1 until the `md_done` cycle. In that cycle `stall`=0 and `rdata`=0x3C.
- Flush: `start`, then `cancel` 1 cycle later, `md_done` 2 cycles after that with `md_lo`=0x12345678 → state DRAIN, `stall`=1 on `mfhi` during DRAIN, `lo` keeps its prior value, IDLE after `md_done`.
- Write ordering: BUSY plus `md_done` (`md_hi`=0xAAAA0000) with `mthi` and `wdata`=0x5555 in the same cycle → `hi`=0x00005555, `rdata` on `mfhi` = 0x5555.
- Watchdog: `MAX_LAT`=8, `start`, no `md_done` → IDLE after 8 cycles, `timeout`=1. A later `md_done` is ignored; `timeout` stays 1 until `reset`.
- Async reset: assert `reset` mid-BUSY between clock edges → `busy`, `hi`, `lo`, `timeout` all go to 0 immediately, without waiting for a clock edge.
